// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared definitions for the radix-4 signed divider: default
//                operand width and iteration count, FSM state encoding and
//                the quotient pattern returned on division by zero.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

   localparam int c_n_default    = 64;
   localparam int c_iter_default = c_n_default / 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ABS  = 3'd1,
      ST_ITER = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } div_state_t;

   // All-ones quotient reported for a zero divisor. Consumers narrower or
   // wider than the default width sign-extend it, which keeps it all ones.
   localparam logic [c_n_default-1:0] c_dbz_quotient = '1;

endpackage
`default_nettype wire

// File: rtl/radix4_digit_select.sv
`default_nettype none
// ============================================================================
//  Module      : radix4_digit_select
//  Description : Combinational radix-4 digit selection. Picks the largest
//                digit q in {0,1,2,3} with q*|d| <= shifted remainder and
//                returns the remainder reduced by q*|d|.
//  Ports       : shifted_rem  - partial remainder after the 2-bit shift (N+2)
//                d1, d2, d3   - |d|, 2|d|, 3|d| (N+2)
//                digit        - selected quotient digit (2)
//                rem_next     - reduced remainder (N)
//  Revision    : 1.0 - initial release
// ============================================================================
module radix4_digit_select
   import div_pkg::*;
#(
   parameter int N = c_n_default
) (
   input  logic [N+1:0] shifted_rem,
   input  logic [N+1:0] d1,
   input  logic [N+1:0] d2,
   input  logic [N+1:0] d3,
   output logic [1:0]   digit,
   output logic [N-1:0] rem_next
);

   // The reduced remainder is always below |d| <= 2^(N-1), so the top two
   // bits of the difference are zero and truncation to N bits is lossless.
   always_comb begin
      digit    = 2'd0;
      rem_next = shifted_rem[N-1:0];
      if (shifted_rem >= d3) begin
         digit    = 2'd3;
         rem_next = N'(shifted_rem - d3);
      end else if (shifted_rem >= d2) begin
         digit    = 2'd2;
         rem_next = N'(shifted_rem - d2);
      end else if (shifted_rem >= d1) begin
         digit    = 2'd1;
         rem_next = N'(shifted_rem - d1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/radix4_divider_64.sv
`default_nettype none
// ============================================================================
//  Module      : radix4_divider_64
//  Description : Iterative radix-4 signed divider with valid/ready handshakes.
//                Restoring division on operand magnitudes, two quotient bits
//                per cycle, sign fix-up at the end. Latency from the
//                accepting edge to out_valid is a constant ITER+2 cycles.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                in_valid/in_ready   - operand handshake (ready only in IDLE)
//                dividend, divisor   - signed operands (N)
//                out_valid/out_ready - result handshake (valid only in DONE)
//                quotient, remainder - signed results (N), held outside DONE
//                div_by_zero         - result came from a zero divisor
//  Revision    : 1.0 - initial release
// ============================================================================
module radix4_divider_64
   import div_pkg::*;
#(
   parameter int N    = c_n_default,   // must be even
   parameter int ITER = N / 2          // N/2 digits give the full quotient
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int            CW          = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] c_last_iter = CW'(ITER - 1);
   localparam logic [N-1:0]  c_dbz_q     = N'(signed'(c_dbz_quotient));

   div_state_t    r_state;
   div_state_t    w_state_next;

   logic [N-1:0]  r_dividend;
   logic [N-1:0]  r_divisor;
   logic [N-1:0]  r_a_mag;      // dividend magnitude, consumed MSB first
   logic [N+1:0]  r_d1;
   logic [N+1:0]  r_d2;
   logic [N+1:0]  r_d3;
   logic [N-1:0]  r_rem;
   logic [N-1:0]  r_quo;
   logic [CW-1:0] r_cnt;
   logic          r_q_neg;
   logic          r_r_neg;
   logic          r_dbz;

   logic [N-1:0]  w_a_mag;
   logic [N-1:0]  w_d_mag;
   logic [N+1:0]  w_shifted;
   logic [1:0]    w_digit;
   logic [N-1:0]  w_rem_next;

   // Unary minus of -2^(N-1) wraps back to 0x80..0, which read as unsigned
   // is exactly 2^(N-1), so the most negative operand loses nothing.
   assign w_a_mag   = r_dividend[N-1] ? -r_dividend : r_dividend;
   assign w_d_mag   = r_divisor[N-1]  ? -r_divisor  : r_divisor;
   assign w_shifted = {r_rem, r_a_mag[N-1 -: 2]};

   radix4_digit_select #(
      .N (N)
   ) u_digit_select (
      .shifted_rem (w_shifted),
      .d1          (r_d1),
      .d2          (r_d2),
      .d3          (r_d3),
      .digit       (w_digit),
      .rem_next    (w_rem_next)
   );

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and handshake outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_next = ST_ABS;
            end
         end
         ST_ABS: begin
            w_state_next = ST_ITER;
         end
         ST_ITER: begin
            if (r_cnt == c_last_iter) begin
               w_state_next = ST_FIX;
            end
         end
         ST_FIX: begin
            w_state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_a_mag     <= '0;
         r_d1        <= '0;
         r_d2        <= '0;
         r_d3        <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_cnt       <= '0;
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_dbz       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_dividend <= dividend;
                  r_divisor  <= divisor;
               end
            end
            ST_ABS: begin
               r_a_mag <= w_a_mag;
               r_d1    <= {2'b00, w_d_mag};
               r_d2    <= {1'b0, w_d_mag, 1'b0};
               r_d3    <= {2'b00, w_d_mag} + {1'b0, w_d_mag, 1'b0};
               r_rem   <= '0;
               r_quo   <= '0;
               r_cnt   <= '0;
               r_q_neg <= r_dividend[N-1] ^ r_divisor[N-1];
               r_r_neg <= r_dividend[N-1];
               r_dbz   <= (r_divisor == '0);
            end
            ST_ITER: begin
               r_rem   <= w_rem_next;
               r_quo   <= {r_quo[N-3:0], w_digit};
               r_a_mag <= {r_a_mag[N-3:0], 2'b00};
               r_cnt   <= r_cnt + CW'(1);
            end
            ST_FIX: begin
               // A zero divisor still runs every iteration so the latency
               // stays constant; its result is simply overridden here.
               if (r_dbz) begin
                  quotient  <= c_dbz_q;
                  remainder <= r_dividend;
               end else begin
                  quotient  <= r_q_neg ? -r_quo : r_quo;
                  remainder <= r_r_neg ? -r_rem : r_rem;
               end
               div_by_zero <= r_dbz;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_radix4_divider_64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_radix4_divider_64
//  Description : Scoreboard testbench for radix4_divider_64. A driver pushes
//                the expected result of every accepted pair; a monitor pops
//                and compares whenever a result is handed over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_radix4_divider_64;

   localparam int           N   = 64;
   localparam int           LAT = N / 2 + 2;
   localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b1;
   logic [N-1:0] dividend  = '0;
   logic [N-1:0] divisor   = '0;
   logic         in_ready;
   logic         out_valid;
   logic         div_by_zero;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;

   radix4_divider_64 #(
      .N    (N),
      .ITER (N / 2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] d;
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dbz;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   n_tests    = 0;
   int   n_fail     = 0;
   int   cyc        = 0;
   int   ready_mode = 0;   // 0: always ready, 1: random stalls, 2: 10-cycle stall
   int   stall_cnt  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(string name, string what);
      n_tests++;
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   function automatic logic [N-1:0] mag(logic [N-1:0] x);
      return x[N-1] ? -x : x;
   endfunction

   // Reference model: plain signed arithmetic plus the two special cases.
   function automatic exp_t model(logic [N-1:0] a, logic [N-1:0] d);
      exp_t   e;
      longint sa;
      longint sd;
      sa    = signed'(a);
      sd    = signed'(d);
      e.a   = a;
      e.d   = d;
      e.acc = 0;
      if (sd == 0) begin
         e.q   = '1;
         e.r   = a;
         e.dbz = 1'b1;
      end else if (a == MIN && sd == -1) begin
         e.q   = MIN;
         e.r   = '0;
         e.dbz = 1'b0;
      end else begin
         e.q   = sa / sd;
         e.r   = sa % sd;
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [N-1:0] rnd_op(bit is_div);
      logic [N-1:0] v;
      int           k;
      v = {$urandom, $urandom};
      k = $urandom_range(0, 15);
      if (k == 0)      v = is_div ? '0 : MIN;
      else if (k == 1) v = is_div ? '1 : MIN;
      else if (k < 8)  v = $signed(v) >>> $urandom_range(1, N - 2);
      return v;
   endfunction

   // ------------------------------------------------------------------------
   // Driver
   // ------------------------------------------------------------------------
   task automatic send(input exp_t e, output int acc);
      int waited = 0;
      acc = -1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         // Garbage offered while busy must be ignored.
         in_valid = 1'($urandom_range(0, 1));
         dividend = {$urandom, $urandom};
         divisor  = {$urandom, $urandom};
         waited++;
         if (waited > 500) begin
            fail_now("in_ready_timeout", "in_ready never rose");
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b1;
      dividend = e.a;
      divisor  = e.d;
      e.acc    = cyc + 1;
      acc      = e.acc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = {$urandom, $urandom};
      divisor  = {$urandom, $urandom};
   endtask

   task automatic send_exp(logic [N-1:0] a, logic [N-1:0] d,
                           logic [N-1:0] q, logic [N-1:0] r, logic z);
      exp_t e;
      int   acc;
      e.a = a; e.d = d; e.q = q; e.r = r; e.dbz = z; e.acc = 0;
      send(e, acc);
   endtask

   task automatic send_rnd();
      int acc;
      send(model(rnd_op(1'b0), rnd_op(1'b1)), acc);
   endtask

   task automatic drain();
      int waited = 0;
      while (sb.size() != 0) begin
         @(negedge clk);
         waited++;
         if (waited > 2000) begin
            fail_now("drain_timeout", "expected results never delivered");
            sb.delete();
         end
      end
      repeat (2) @(negedge clk);
   endtask

   // ------------------------------------------------------------------------
   // Consumer ready generation
   // ------------------------------------------------------------------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (out_valid && stall_cnt < 10) begin
                  out_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  out_ready = 1'b1;
                  if (!out_valid) stall_cnt = 0;
               end
            end
            default: out_ready = 1'b1;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------------
   exp_t         cur;
   bit           have       = 1'b0;
   bit           stable_ok  = 1'b1;
   bit           hold_armed = 1'b0;
   bit           hold_ok    = 1'b1;
   logic [N-1:0] snap_q, snap_r, last_q, last_r;
   logic         snap_z, last_z;

   always @(negedge clk) begin
      if (reset) begin
         have       = 1'b0;
         hold_armed = 1'b0;
      end else if (out_valid) begin
         if (!have) begin
            have      = 1'b1;
            stable_ok = !in_ready;
            snap_q    = quotient;
            snap_r    = remainder;
            snap_z    = div_by_zero;
            if (sb.size() == 0) begin
               fail_now("unexpected_out", "out_valid with no pending operation");
            end else begin
               check_int("latency", cyc - sb[0].acc, LAT);
               if (hold_armed) begin
                  n_tests++;
                  if (!hold_ok) begin
                     n_fail++;
                     $display("FAIL hold: outputs changed outside DONE, last q %h r %h", last_q, last_r);
                  end
               end
            end
         end else if (quotient !== snap_q || remainder !== snap_r ||
                      div_by_zero !== snap_z || in_ready) begin
            stable_ok = 1'b0;
         end
         if (out_ready && have) begin
            if (sb.size() != 0) begin
               cur = sb.pop_front();
               check("quotient", quotient, cur.q);
               check("remainder", remainder, cur.r);
               check("div_by_zero", {{(N-1){1'b0}}, div_by_zero}, {{(N-1){1'b0}}, cur.dbz});
               check("stable_in_done", {{(N-1){1'b0}}, stable_ok}, {{(N-1){1'b0}}, 1'b1});
               if (!cur.dbz) begin
                  check("identity", quotient * cur.d + remainder, cur.a);
                  check("rem_bound", {{(N-1){1'b0}}, (mag(remainder) < mag(cur.d))},
                        {{(N-1){1'b0}}, 1'b1});
               end
               last_q     = cur.q;
               last_r     = cur.r;
               last_z     = cur.dbz;
               hold_armed = 1'b1;
               hold_ok    = 1'b1;
            end
            have = 1'b0;
         end
      end else if (hold_armed) begin
         if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_z)
            hold_ok = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      int acc;
      int seen;
      exp_t e;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready", {{(N-1){1'b0}}, in_ready}, {{(N-1){1'b0}}, 1'b1});
      check("reset_out_valid", {{(N-1){1'b0}}, out_valid}, '0);
      check("reset_quotient", quotient, '0);
      check("reset_remainder", remainder, '0);
      check("reset_div_by_zero", {{(N-1){1'b0}}, div_by_zero}, '0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Directed cases with hand-derived results.
      send_exp(64'd100, 64'd7, 64'd14, 64'd2, 1'b0);
      send_exp(-64'sd100, 64'd7, -64'sd14, -64'sd2, 1'b0);
      send_exp(64'd100, -64'sd7, -64'sd14, 64'd2, 1'b0);
      send_exp(MIN, -64'sd1, MIN, 64'd0, 1'b0);
      send_exp(64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd12345, 1'b1);
      send_exp(-64'sd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, -64'sd12345, 1'b1);
      send_exp(MIN, 64'd1, MIN, 64'd0, 1'b0);
      send_exp(64'h7FFF_FFFF_FFFF_FFFF, MIN, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      send_exp(MIN, MIN, 64'd1, 64'd0, 1'b0);
      send_exp(-64'sd7, 64'd100, 64'd0, -64'sd7, 1'b0);
      send_exp(MIN, 64'd3, -64'sd3074457345618258602, -64'sd2, 1'b0);
      drain();

      // Consumer holds off for 10 cycles in DONE.
      ready_mode = 2;
      send_exp(64'd1000, -64'sd33, -64'sd30, 64'd10, 1'b0);
      drain();
      ready_mode = 0;

      // Reset during iteration 15: abort with no result.
      e = model(64'd987654321, 64'd1234);
      send(e, acc);
      while (acc >= 0 && cyc < acc + 16) @(negedge clk);
      reset = 1'b1;
      if (sb.size() != 0) void'(sb.pop_back());
      @(negedge clk);
      reset = 1'b0;
      check("abort_in_ready", {{(N-1){1'b0}}, in_ready}, {{(N-1){1'b0}}, 1'b1});
      check("abort_out_valid", {{(N-1){1'b0}}, out_valid}, '0);
      check("abort_quotient", quotient, '0);
      seen = 0;
      repeat (LAT + 6) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_int("abort_no_out_valid", seen, 0);

      // Randomized pairs with random consumer stalls.
      ready_mode = 1;
      for (int i = 0; i < 1000; i++) send_rnd();
      drain();
      ready_mode = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
